// File: rtl/conv2d_pkg.sv
// Shared helpers for the strided 2D convolution: geometry of the output frame,
// counter sizing and the requantise (shift + saturate) step.
package conv2d_pkg;

  function automatic int cnt_w(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

  function automatic int out_width(input int w, input int k, input int s);
    return (w - k) / s + 1;
  endfunction

  function automatic int out_height(input int h, input int k, input int s);
    return (h - k) / s + 1;
  endfunction

  function automatic int last_x(input int w, input int k, input int s);
    return k - 1 + (out_width(w, k, s) - 1) * s;
  endfunction

  function automatic int last_y(input int h, input int k, input int s);
    return k - 1 + (out_height(h, k, s) - 1) * s;
  endfunction

  // Arithmetic shift, then clamp into a signed field of width_out bits.
  function automatic logic signed [63:0] requant(input logic signed [63:0] acc,
                                                 input int shift,
                                                 input int width_out);
    logic signed [63:0] shifted;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    shifted = acc >>> shift;
    hi      = (64'sd1 <<< (width_out - 1)) - 64'sd1;
    lo      = -hi - 64'sd1;
    if (shifted > hi) return hi;
    if (shifted < lo) return lo;
    return shifted;
  endfunction

endpackage

// File: rtl/conv2d_strided_if.sv
// Pixel-in / result-out stream bundle; signal names are from the block's point of view.
interface conv2d_strided_if #(
  parameter int DataW = 2,
  parameter int OutW  = 16
);
  logic                   valid_i;
  logic                   ready_o;
  logic [DataW-1:0]       data_i;
  logic                   valid_o;
  logic                   ready_i;
  logic signed [OutW-1:0] data_o;
  logic                   last_o;

  modport slave (
    input  valid_i, data_i, ready_i,
    output ready_o, valid_o, data_o, last_o
  );

  modport master (
    output valid_i, data_i, ready_i,
    input  ready_o, valid_o, data_o, last_o
  );
endinterface

// File: rtl/conv2d_mac.sv
// Combinational K x K x Channels multiply-accumulate followed by requantisation.
module conv2d_mac
  import conv2d_pkg::*;
#(
  parameter int Channels    = 1,
  parameter int WidthIn     = 2,
  parameter int SignedIn    = 0,
  parameter int KernelWidth = 3,
  parameter int WeightWidth = 2,
  parameter int AccWidth    = 32,
  parameter int WidthOut    = 16
) (
  input  logic [Channels*KernelWidth*KernelWidth*WidthIn-1:0]     win_i,
  input  logic [Channels*KernelWidth*KernelWidth*WeightWidth-1:0] weights_i,
  input  logic [$clog2(AccWidth)-1:0]                             shift_i,
  output logic signed [WidthOut-1:0]                              data_o
);
  localparam int Taps = Channels * KernelWidth * KernelWidth;

  logic signed [AccWidth-1:0] term [Taps];
  logic signed [AccWidth-1:0] acc;

  // Window and weights share the (c*K + r)*K + col layout, so tap i pairs directly.
  for (genvar i = 0; i < Taps; i++) begin : g_term
    logic [WidthIn-1:0]            px;
    logic signed [WeightWidth-1:0] wt;
    assign px = win_i[i*WidthIn +: WidthIn];
    assign wt = weights_i[i*WeightWidth +: WeightWidth];
    if (WidthIn == 1) begin : g_bin
      assign term[i] = px[0] ? AccWidth'(wt) : '0;
    end else if (SignedIn != 0) begin : g_sgn
      assign term[i] = AccWidth'(wt) * AccWidth'($signed(px));
    end else begin : g_uns
      assign term[i] = AccWidth'(wt) * $signed(AccWidth'(px));
    end
  end

  always_comb begin
    acc = '0;
    for (int i = 0; i < Taps; i++) acc = acc + term[i];
  end

  assign data_o = WidthOut'(requant(64'(acc), int'(shift_i), WidthOut));
endmodule

// File: rtl/delaybuffer.sv
// Fixed-depth delay line advancing only on an accepted beat; contents are not reset.
module delaybuffer #(
  parameter int Width = 8,
  parameter int Depth = 4
) (
  input  logic             clk_i,
  input  logic             valid_i,
  input  logic             ready_i,
  input  logic [Width-1:0] data_i,
  output logic [Width-1:0] data_o
);
  logic [Width-1:0] mem_q [Depth];

  always_ff @(posedge clk_i) begin
    if (valid_i & ready_i) begin
      mem_q[0] <= data_i;
      for (int i = 1; i < Depth; i++) mem_q[i] <= mem_q[i-1];
    end
  end

  assign data_o = mem_q[Depth-1];
endmodule

// File: rtl/conv2d_strided.sv
// Strided multi-channel 2D convolution over a raster pixel stream with a
// single output register and last-of-frame tagging.
module conv2d_strided
  import conv2d_pkg::*;
#(
  parameter int LineWidthPx = 160,
  parameter int LineCountPx = 120,
  parameter int Channels    = 1,
  parameter int WidthIn     = 2,
  parameter int SignedIn    = 0,
  parameter int KernelWidth = 3,
  parameter int Stride      = 1,
  parameter int WeightWidth = 2,
  parameter int AccWidth    = 32,
  parameter int WidthOut    = 16
) (
  input  logic                                                    clk_i,
  input  logic                                                    rst_ni,
  conv2d_strided_if.slave                                         bus,
  input  logic [Channels*KernelWidth*KernelWidth*WeightWidth-1:0] weights_i,
  input  logic [$clog2(AccWidth)-1:0]                             shift_i
);
  localparam int K     = KernelWidth;
  localparam int PixW  = Channels * WidthIn;
  localparam int WinW  = Channels * K * K * WidthIn;
  localparam int XW    = cnt_w(LineWidthPx);
  localparam int YW    = cnt_w(LineCountPx);
  localparam int PW    = cnt_w(Stride);
  localparam int LastX = last_x(LineWidthPx, K, Stride);
  localparam int LastY = last_y(LineCountPx, K, Stride);

  logic                       in_fire;
  logic                       produce;
  logic                       frame_end;
  logic [XW-1:0]              x_q, x_d;
  logic [YW-1:0]              y_q, y_d;
  logic [PW-1:0]              xph_q, xph_d, xph_cur;
  logic [PW-1:0]              yph_q, yph_d, yph_cur;
  logic [WinW-1:0]            win_q, win_d;
  logic [PixW-1:0]            lb_in  [K-1];
  logic [PixW-1:0]            lb_tap [K-1];
  logic                       valid_q, valid_d;
  logic                       last_q, last_d;
  logic signed [WidthOut-1:0] data_q, data_d;
  logic signed [WidthOut-1:0] mac_out;

  assign bus.ready_o = ~valid_q | bus.ready_i;
  assign in_fire     = bus.valid_i & bus.ready_o;

  // Phases restart at the first full-window column/row and count modulo Stride.
  always_comb begin
    xph_cur = (x_q == XW'(K-1)) ? '0 : xph_q;
    yph_cur = (y_q == YW'(K-1)) ? '0 : yph_q;
    x_d     = x_q;
    y_d     = y_q;
    xph_d   = xph_q;
    yph_d   = yph_q;
    if (in_fire) begin
      xph_d = (xph_cur == PW'(Stride-1)) ? '0 : xph_cur + PW'(1);
      if (x_q == XW'(LineWidthPx-1)) begin
        x_d   = '0;
        yph_d = (yph_cur == PW'(Stride-1)) ? '0 : yph_cur + PW'(1);
        y_d   = (y_q == YW'(LineCountPx-1)) ? '0 : y_q + YW'(1);
      end else begin
        x_d = x_q + XW'(1);
      end
    end
  end

  assign produce   = in_fire && (x_q >= XW'(K-1)) && (y_q >= YW'(K-1)) &&
                     (xph_cur == '0) && (yph_cur == '0);
  assign frame_end = (x_q == XW'(LastX)) && (y_q == YW'(LastY));

  // Line buffer m is fed by the newest column of window row K-1-m and returns
  // that row's pixel one line later as the new column entry of row K-2-m.
  always_comb begin
    for (int m = 0; m < K-1; m++) begin
      lb_in[m] = '0;
      for (int c = 0; c < Channels; c++)
        lb_in[m][c*WidthIn +: WidthIn] = win_q[((c*K + (K-1-m))*K + K-1)*WidthIn +: WidthIn];
    end
  end

  for (genvar m = 0; m < K-1; m++) begin : g_line
    delaybuffer #(
      .Width (PixW),
      .Depth (LineWidthPx-1)
    ) u_line (
      .clk_i   (clk_i),
      .valid_i (in_fire),
      .ready_i (1'b1),
      .data_i  (lb_in[m]),
      .data_o  (lb_tap[m])
    );
  end

  always_comb begin
    win_d = win_q;
    if (in_fire) begin
      for (int c = 0; c < Channels; c++) begin
        for (int r = 0; r < K; r++) begin
          for (int j = 0; j < K-1; j++)
            win_d[((c*K + r)*K + j)*WidthIn +: WidthIn] = win_q[((c*K + r)*K + j + 1)*WidthIn +: WidthIn];
          if (r == K-1)
            win_d[((c*K + r)*K + K-1)*WidthIn +: WidthIn] = bus.data_i[c*WidthIn +: WidthIn];
          else
            win_d[((c*K + r)*K + K-1)*WidthIn +: WidthIn] =
              lb_tap[(r < K-1) ? (K-2-r) : 0][c*WidthIn +: WidthIn];
        end
      end
    end
  end

  // The MAC sees the post-shift window so the producing pixel is included.
  conv2d_mac #(
    .Channels    (Channels),
    .WidthIn     (WidthIn),
    .SignedIn    (SignedIn),
    .KernelWidth (K),
    .WeightWidth (WeightWidth),
    .AccWidth    (AccWidth),
    .WidthOut    (WidthOut)
  ) u_mac (
    .win_i     (win_d),
    .weights_i (weights_i),
    .shift_i   (shift_i),
    .data_o    (mac_out)
  );

  always_comb begin
    valid_d = valid_q;
    last_d  = last_q;
    data_d  = data_q;
    if (bus.ready_o) valid_d = produce;
    if (produce) begin
      last_d = frame_end;
      data_d = mac_out;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      x_q     <= '0;
      y_q     <= '0;
      xph_q   <= '0;
      yph_q   <= '0;
      win_q   <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      data_q  <= '0;
    end else begin
      x_q     <= x_d;
      y_q     <= y_d;
      xph_q   <= xph_d;
      yph_q   <= yph_d;
      win_q   <= win_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      data_q  <= data_d;
    end
  end

  assign bus.valid_o = valid_q;
  assign bus.data_o  = data_q;
  assign bus.last_o  = last_q;
endmodule
